// File: rtl/tetris_frame_composer.sv
// tetris_frame_composer: builds the 40x30 block bitmap for the VGA renderer.
// Merges the locked playfield, the falling 4x4 piece and the U-shaped well
// border one screen row per cycle into a shadow buffer, then commits the
// whole frame in a single cycle so the renderer never sees a partial frame.
// Optional build macro TFC_OVERLAP_EN adds the registered `overlap` output
// (piece cell lands on a filled board cell).
module tetris_frame_composer #(
  parameter int ORG_X = 15,
  parameter int ORG_Y = 5
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           start,
  input  logic [0:199]   board,
  input  logic [15:0]    piece,
  input  logic [4:0]     piece_x,
  input  logic [5:0]     piece_y,
  output logic           busy,
  output logic           done,
  output logic [0:1199]  frame
`ifdef TFC_OVERLAP_EN
  ,
  output logic           overlap
`endif
);

  typedef enum logic [1:0] {IDLE, COMPOSE, COMMIT} state_t;

  localparam logic [4:0] Y0  = 5'(ORG_Y);
  localparam logic [4:0] Y20 = 5'(ORG_Y + 20);

  state_t        state;
  logic [4:0]    row;
  logic [0:1199] shadow;
  logic [0:199]  snap_board;
  logic [15:0]   snap_piece;
  logic [4:0]    snap_px;
  logic [5:0]    snap_py;

  logic [0:39]   row_bits;
  logic [10:0]   row_base;
  logic [4:0]    by;
  logic          in_r, in_rb, is_floor;

  // Row-wide decode shared by every column of the current screen row
  assign in_r     = (row >= Y0) && (row < Y20);
  assign in_rb    = (row >= Y0) && (row <= Y20);
  assign is_floor = (row == Y20);
  assign by       = row - Y0;
  assign row_base = 11'(row) * 11'd40;

`ifdef TFC_OVERLAP_EN
  logic [0:39] row_ovl;
  logic        ovl_acc;
`endif

  // One pixel per screen column; playfield columns are the only ones that
  // ever look at board/piece, so the rest reduce to constants or the border.
  for (genvar c = 0; c < 40; c++) begin : g_col
    if (c >= ORG_X && c < ORG_X + 10) begin : g_pf
      localparam logic [6:0] CX = 7'(c - ORG_X);
      logic [6:0] dx, dy;
      logic [7:0] bidx;
      logic       bb, pp;
      // 7-bit signed offsets so negative piece coordinates never wrap
      assign dx   = CX - {{2{snap_px[4]}}, snap_px};
      assign dy   = {2'b00, by} - {snap_py[5], snap_py};
      assign bidx = {3'b000, by} * 8'd10 + {1'b0, CX};
      assign bb   = in_r & snap_board[bidx];
      assign pp   = in_r & (dx[6:2] == 5'd0) & (dy[6:2] == 5'd0)
                  & snap_piece[{dy[1:0], dx[1:0]}];
      assign row_bits[c] = bb | pp | is_floor;
`ifdef TFC_OVERLAP_EN
      assign row_ovl[c] = bb & pp;
`endif
    end else if (c == ORG_X - 1 || c == ORG_X + 10) begin : g_wall
      assign row_bits[c] = in_rb;
`ifdef TFC_OVERLAP_EN
      assign row_ovl[c] = 1'b0;
`endif
    end else begin : g_blank
      assign row_bits[c] = 1'b0;
`ifdef TFC_OVERLAP_EN
      assign row_ovl[c] = 1'b0;
`endif
    end
  end

  // Control FSM: snapshot inputs, compose 30 rows, commit in one cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      row        <= '0;
      shadow     <= '0;
      frame      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      snap_board <= '0;
      snap_piece <= '0;
      snap_px    <= '0;
      snap_py    <= '0;
`ifdef TFC_OVERLAP_EN
      ovl_acc    <= 1'b0;
      overlap    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_board <= board;
            snap_piece <= piece;
            snap_px    <= piece_x;
            snap_py    <= piece_y;
            busy       <= 1'b1;
            row        <= '0;
            state      <= COMPOSE;
`ifdef TFC_OVERLAP_EN
            ovl_acc    <= 1'b0;
`endif
          end
        end
        COMPOSE: begin
          shadow[row_base +: 40] <= row_bits;
`ifdef TFC_OVERLAP_EN
          ovl_acc <= ovl_acc | (|row_ovl);
`endif
          if (row == 5'd29) state <= COMMIT;
          else              row   <= row + 5'd1;
        end
        COMMIT: begin
          frame <= shadow;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef TFC_OVERLAP_EN
          overlap <= ovl_acc;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_frame_composer.sv
// Directed bench for tetris_frame_composer (ORG_X=15, ORG_Y=5).
module tb_tetris_frame_composer;

  logic          clk = 1'b0;
  logic          clrn;
  logic          start;
  logic [0:199]  board;
  logic [15:0]   piece;
  logic [4:0]    piece_x;
  logic [5:0]    piece_y;
  logic          busy, done;
  logic [0:1199] frame;
`ifdef TFC_OVERLAP_EN
  logic          overlap;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  tetris_frame_composer dut (
    .clk(clk), .clrn(clrn), .start(start), .board(board), .piece(piece),
    .piece_x(piece_x), .piece_y(piece_y), .busy(busy), .done(done),
    .frame(frame)
`ifdef TFC_OVERLAP_EN
    , .overlap(overlap)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1199:0] got, input logic [1199:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Well border: columns 14 and 25 over rows 5..25, floor row 25 cols 14..25
  function automatic logic [0:1199] wall();
    logic [0:1199] e;
    e = '0;
    for (int r = 5; r <= 25; r++) begin
      e[r*40+14] = 1'b1;
      e[r*40+25] = 1'b1;
    end
    for (int c = 14; c <= 25; c++) e[25*40+c] = 1'b1;
    return e;
  endfunction

  // Pulse start, scramble inputs, wait for done (bounded)
  task automatic compose(input string tag, input logic [0:1199] exp);
    logic [0:1199] prev;
    int  lat;
    bit  stale_ok;
    logic b_after;
    prev = frame;
    start = 1'b1;
    tick();
    start = 1'b0;
    b_after = busy;
    board = ~board; piece = ~piece; piece_x = ~piece_x; piece_y = ~piece_y;
    lat = 0; stale_ok = 1'b1;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
      else if (frame !== prev) stale_ok = 1'b0;
    end
    chk({tag, "_busy"}, 1200'(b_after), 1200'(1));
    chk({tag, "_lat"}, 1200'(lat), 1200'(31));
    chk({tag, "_hold"}, 1200'(stale_ok), 1200'(1));
    chk({tag, "_frame"}, frame, exp);
    tick();
    chk({tag, "_done_end"}, 1200'({done, busy}), 1200'(0));
  endtask

  initial begin
    logic [0:1199] e;
    int nd, d1, d2;
    clrn = 1'b0; start = 1'b0; board = '0; piece = '0; piece_x = '0; piece_y = '0;
    #12;
    chk("rst_frame", frame, '0);
    chk("rst_ctl", 1200'({busy, done}), 1200'(0));
    clrn = 1'b1;
    tick();

    // empty board, no piece: border only
    board = '0; piece = '0; piece_x = '0; piece_y = '0;
    compose("empty", wall());

    // board cell (0,0)
    board = '0; board[0] = 1'b1; piece = '0; piece_x = '0; piece_y = '0;
    e = wall(); e[215] = 1'b1;
    compose("b0", e);
    chk("b0_215", 1200'(frame[215]), 1200'(1));
    chk("b0_216", 1200'(frame[216]), 1200'(0));

    // 2x2 piece at (4,0)
    board = '0; piece = 16'h0033; piece_x = 5'd4; piece_y = 6'd0;
    e = wall(); e[219] = 1'b1; e[220] = 1'b1; e[259] = 1'b1; e[260] = 1'b1;
    compose("sq", e);
`ifdef TFC_OVERLAP_EN
    chk("sq_ovl", 1200'(overlap), 1200'(0));
`endif

    // 2x2 piece at (-1,-1): clipped to cell (0,0)
    board = '0; piece = 16'h0033; piece_x = 5'h1F; piece_y = 6'h3F;
    e = wall(); e[215] = 1'b1;
    compose("clip", e);

    // board bit 14 is playfield (1,4) = screen (6,19) = bit 259
    board = '0; board[14] = 1'b1; piece = 16'h0033; piece_x = 5'd4; piece_y = 6'd0;
    e = wall(); e[219] = 1'b1; e[220] = 1'b1; e[259] = 1'b1; e[260] = 1'b1;
    compose("ov1", e);
`ifdef TFC_OVERLAP_EN
    chk("ov1_ovl", 1200'(overlap), 1200'(1));
`endif
    board = '0; board[14] = 1'b1; piece = 16'h0033; piece_x = 5'd6; piece_y = 6'd0;
    e = wall(); e[259] = 1'b1; e[221] = 1'b1; e[222] = 1'b1; e[261] = 1'b1; e[262] = 1'b1;
    compose("ov0", e);
`ifdef TFC_OVERLAP_EN
    chk("ov0_ovl", 1200'(overlap), 1200'(0));
`endif

    // second start at T+10 is ignored
    board = '0; piece = '0; piece_x = '0; piece_y = '0;
    nd = 0; d1 = 0;
    for (int i = 0; i <= 45; i++) begin
      start = (i == 0) || (i == 10);
      tick();
      if (done) begin nd++; d1 = i; end
    end
    start = 1'b0;
    chk("ign_count", 1200'(nd), 1200'(1));
    chk("ign_when", 1200'(d1), 1200'(31));

    // reset in the middle of a composition
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    clrn = 1'b0;
    #1;
    chk("abort_ctl", 1200'({busy, done}), 1200'(0));
    chk("abort_frame", frame, '0);
    #2 clrn = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) nd++;
    end
    chk("abort_nodone", 1200'(nd), 1200'(0));
    chk("abort_frame2", frame, '0);

    // start held high: back-to-back frames 32 cycles apart
    board = '0; board[199] = 1'b1; piece = '0;
    start = 1'b1;
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (done) begin
        if (d1 == 0) d1 = i; else if (d2 == 0) d2 = i;
      end
    end
    start = 1'b0;
    chk("held_first", 1200'(d1), 1200'(32));
    chk("held_second", 1200'(d2), 1200'(64));
    e = wall(); e[24*40+24] = 1'b1;
    chk("held_frame", frame, e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
